// File: rtl/kbd_pkg.sv
// ============================================================================
// Module      : kbd_pkg
// Description : Shared types and scancode constants for the keyboard event
//               controller (event struct, FSM states, set-2 prefix/key codes).
//               Optional feature macro: KBD_REPEAT_FILTER_EN (used by the top).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

    // One decoded key event as stored in the event FIFO
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    // Byte-sequencing FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_GAP    = 2'd2
    } kbd_state_e;

    // Scancode set 2 prefixes
    localparam logic [7:0] C_SC_E0     = 8'hE0;
    localparam logic [7:0] C_SC_F0     = 8'hF0;
    localparam logic [7:0] C_SC_E1     = 8'hE1;

    // Modifier key codes
    localparam logic [7:0] C_SC_LSHIFT = 8'h12;
    localparam logic [7:0] C_SC_RSHIFT = 8'h59;
    localparam logic [7:0] C_SC_CTRL   = 8'h14;
    localparam logic [7:0] C_SC_ALT    = 8'h11;
    localparam logic [7:0] C_SC_CAPS   = 8'h58;

    // Bytes following E1 that belong to the Pause sequence
    localparam logic [2:0] C_E1_SKIP_LEN = 3'd7;

endpackage

`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
// ============================================================================
// Module      : kbd_evt_fifo
// Description : First-word-fall-through FIFO of kbd_evt_t. Head reads as zero
//               while empty. A pop while full frees a slot for a same-cycle
//               push; a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     i_push,
    input  kbd_evt_t                 i_evt,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output kbd_evt_t                 o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    kbd_evt_t          r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; no reset needed since the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_evt;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/kbd_event_ctrl.sv
// ============================================================================
// Module      : kbd_event_ctrl
// Description : Pops bytes from the PS/2 receiver (IDLE/DECODE/GAP handshake),
//               decodes set-2 scancodes with E0/F0/E1 prefixes into key
//               events, tracks modifiers and buffers events in a FWFT FIFO.
//               Optional macro KBD_REPEAT_FILTER_EN suppresses typematic
//               repeats of the most recent make.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_ready,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_overflow,
    output logic                          ps2_nextdata_n,
    input  logic                          rd_en,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [3:0]                    mods,
    input  logic                          ovf_clr,
    output logic                          evt_ovf,
    output logic                          ps2_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    kbd_state_e  r_state, w_state_nxt;
    logic        w_decode;
    logic [7:0]  r_byte;
    logic        r_ext, r_brk;
    logic [2:0]  r_skip;
    logic        r_lshift, r_rshift, r_ctrl, r_alt, r_caps_held, r_caps_lock;
    logic        r_evt_ovf, r_ps2_ovf;
    kbd_evt_t    w_evt, w_head;
    logic        w_formed, w_filtered, w_push, w_full, w_empty;

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and pop strobe; the strobe is low only during DECODE
    always_comb begin
        w_state_nxt    = r_state;
        ps2_nextdata_n = 1'b1;
        w_decode       = 1'b0;
        case (r_state)
            ST_IDLE:   if (ps2_ready) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                ps2_nextdata_n = 1'b0;
                w_decode       = 1'b1;
                w_state_nxt    = ST_GAP;
            end
            ST_GAP:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the receiver head byte when leaving IDLE
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                               r_byte <= '0;
        else if (r_state == ST_IDLE && ps2_ready) r_byte <= ps2_data;
    end

    assign w_evt    = '{ext: r_ext, brk: r_brk, code: r_byte};
    assign w_formed = w_decode && (r_skip == '0) && (r_byte != C_SC_E1) &&
                      (r_byte != C_SC_E0) && (r_byte != C_SC_F0);
    assign w_push   = w_formed && !w_filtered;

`ifdef KBD_REPEAT_FILTER_EN
    logic        r_last_valid;
    logic [8:0]  r_last_make;
    logic        w_last_hit;

    assign w_last_hit = r_last_valid && (r_last_make == {r_ext, r_byte});
    assign w_filtered = !r_brk && w_last_hit;

    // Remember the latest pushed make; a matching break forgets it
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_last_valid <= 1'b0;
            r_last_make  <= '0;
        end else if (w_push && !r_brk) begin
            r_last_valid <= 1'b1;
            r_last_make  <= {r_ext, r_byte};
        end else if (w_formed && r_brk && w_last_hit) begin
            r_last_valid <= 1'b0;
        end
    end
`else
    assign w_filtered = 1'b0;
`endif

    // Prefix flags and Pause-sequence skip counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_decode) begin
            if (r_skip != '0)            r_skip <= r_skip - 1'b1;
            else if (r_byte == C_SC_E1)  r_skip <= C_E1_SKIP_LEN;
            else if (r_byte == C_SC_E0)  r_ext  <= 1'b1;
            else if (r_byte == C_SC_F0)  r_brk  <= 1'b1;
            else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    // Modifier tracking on every formed event, filtered or not
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_ctrl      <= 1'b0;
            r_alt       <= 1'b0;
            r_caps_held <= 1'b0;
            r_caps_lock <= 1'b0;
        end else if (w_formed) begin
            if (!r_ext && r_byte == C_SC_LSHIFT) r_lshift <= !r_brk;
            if (!r_ext && r_byte == C_SC_RSHIFT) r_rshift <= !r_brk;
            if (r_byte == C_SC_CTRL)             r_ctrl   <= !r_brk;
            if (r_byte == C_SC_ALT)              r_alt    <= !r_brk;
            if (!r_ext && r_byte == C_SC_CAPS) begin
                if (r_brk) begin
                    r_caps_held <= 1'b0;
                end else begin
                    r_caps_held <= 1'b1;
                    if (!r_caps_held) r_caps_lock <= !r_caps_lock;
                end
            end
        end
    end

    // Sticky overflow flags; a same-cycle set beats the clear
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_evt_ovf <= 1'b0;
            r_ps2_ovf <= 1'b0;
        end else begin
            if (w_push && w_full && !rd_en) r_evt_ovf <= 1'b1;
            else if (ovf_clr)               r_evt_ovf <= 1'b0;
            if (ps2_overflow)               r_ps2_ovf <= 1'b1;
            else if (ovf_clr)               r_ps2_ovf <= 1'b0;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (w_push),
        .i_evt   (w_evt),
        .i_pop   (rd_en),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (count)
    );

    assign evt_valid = !w_empty;
    assign evt_code  = w_head.code;
    assign evt_ext   = w_head.ext;
    assign evt_break = w_head.brk;
    assign mods      = {r_caps_lock, r_alt, r_ctrl, r_lshift | r_rshift};
    assign evt_ovf   = r_evt_ovf;
    assign ps2_ovf   = r_ps2_ovf;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_ctrl.sv
// ============================================================================
// Module      : tb_kbd_event_ctrl
// Description : Self-checking bench for kbd_event_ctrl. Emulates the PS/2
//               receiver byte queue and compares against an event-list
//               reference model. Honours KBD_REPEAT_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_event_ctrl;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          ps2_ready = 1'b0;
    logic [7:0]    ps2_data = 8'h00;
    logic          ps2_overflow = 1'b0;
    logic          ps2_nextdata_n;
    logic          rd_en = 1'b0;
    logic          evt_valid;
    logic [7:0]    evt_code;
    logic          evt_ext;
    logic          evt_break;
    logic [3:0]    mods;
    logic          ovf_clr = 1'b0;
    logic          evt_ovf;
    logic          ps2_ovf;
    logic [CW-1:0] count;

    kbd_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .ps2_ready      (ps2_ready),
        .ps2_data       (ps2_data),
        .ps2_overflow   (ps2_overflow),
        .ps2_nextdata_n (ps2_nextdata_n),
        .rd_en          (rd_en),
        .evt_valid      (evt_valid),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .mods           (mods),
        .ovf_clr        (ovf_clr),
        .evt_ovf        (evt_ovf),
        .ps2_ovf        (ps2_ovf),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- receiver emulation ----------------
    logic [7:0] rx_q[$];
    logic [7:0] seq[$];
    int lows = 0, pops = 0, fed = 0;

    task automatic drive_rx();
        ps2_ready = (rx_q.size() != 0);
        ps2_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic step();
        logic pop;
        pop = (ps2_nextdata_n === 1'b0);
        if (pop) lows++;
        @(posedge clk);
        #1;
        if (pop && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pops++;
        end
        drive_rx();
    endtask

    // ---------------- reference model ----------------
    logic       m_ext, m_brk, m_ls, m_rs, m_ctrl, m_alt, m_caps_held, m_caps;
    logic       m_last_valid, m_evt_ovf, m_ps2_ovf;
    logic [8:0] m_last;
    int         m_skip;
    logic [9:0] exp_q[$];

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0;
        m_ls = 0; m_rs = 0; m_ctrl = 0; m_alt = 0; m_caps_held = 0; m_caps = 0;
        m_last_valid = 0; m_last = '0; m_evt_ovf = 0; m_ps2_ovf = 0;
        exp_q.delete();
    endtask

    function automatic logic [3:0] m_mods();
        return {m_caps, m_alt, m_ctrl, m_ls | m_rs};
    endfunction

    task automatic model_byte(input logic [7:0] b);
        bit filt;
        filt = 0;
        if (m_skip > 0)      m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && b == 8'h12) m_ls = !m_brk;
            if (!m_ext && b == 8'h59) m_rs = !m_brk;
            if (b == 8'h14) m_ctrl = !m_brk;
            if (b == 8'h11) m_alt  = !m_brk;
            if (!m_ext && b == 8'h58) begin
                if (m_brk) m_caps_held = 0;
                else begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end
            end
`ifdef KBD_REPEAT_FILTER_EN
            filt = !m_brk && m_last_valid && (m_last == {m_ext, b});
            if (!filt && !m_brk) begin
                m_last_valid = 1; m_last = {m_ext, b};
            end else if (m_brk && m_last_valid && m_last == {m_ext, b}) begin
                m_last_valid = 0;
            end
`endif
            if (!filt) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
                else m_evt_ovf = 1;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Load seq into the receiver and the model, then run until consumed
    task automatic feed();
        int guard;
        foreach (seq[i]) begin
            rx_q.push_back(seq[i]);
            model_byte(seq[i]);
            fed++;
        end
        guard = 3 * seq.size() + 20;
        seq.delete();
        drive_rx();
        while (rx_q.size() > 0 && guard > 0) begin
            step();
            guard--;
        end
        if (rx_q.size() > 0) check("rx_drain_timeout", rx_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_mods"},    mods,    m_mods());
        check({tag, "_count"},   count,   exp_q.size());
        check({tag, "_evt_ovf"}, evt_ovf, m_evt_ovf);
        check({tag, "_ps2_ovf"}, ps2_ovf, m_ps2_ovf);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = DEPTH + 4;
        while (exp_q.size() > 0 && guard > 0) begin
            check({tag, "_valid"}, evt_valid, 1);
            check({tag, "_event"}, {evt_ext, evt_break, evt_code}, exp_q[0]);
            rd_en = 1;
            step();
            rd_en = 0;
            void'(exp_q.pop_front());
            check({tag, "_count_after_pop"}, count, exp_q.size());
            guard--;
        end
        check({tag, "_empty_valid"}, evt_valid, 0);
        check({tag, "_empty_head"}, {evt_ext, evt_break, evt_code}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nextdata_n"}, ps2_nextdata_n, 1);
        check({tag, "_valid"},      evt_valid, 0);
        check({tag, "_count"},      count, 0);
        check({tag, "_head"},       {evt_ext, evt_break, evt_code}, 0);
        check({tag, "_mods"},       mods, 0);
        check({tag, "_ovf"},        {evt_ovf, ps2_ovf}, 0);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 15))
            0:       return 8'hE0;
            1, 2:    return 8'hF0;
            3:       return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
            4:       return 8'h12;
            5:       return 8'h59;
            6:       return 8'h14;
            7:       return 8'h11;
            8:       return 8'h58;
            default: return 8'($urandom_range(8'h15, 8'h7F));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive_rx();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        clrn = 1;
        step();

        // Latency: ready in cycle n, strobe low in n+1, event in n+2
        rx_q.push_back(8'h1C); model_byte(8'h1C); fed++;
        drive_rx();
        step();
        check("lat_strobe_low", ps2_nextdata_n, 0);
        check("lat_not_yet_valid", evt_valid, 0);
        step();
        check("lat_strobe_high", ps2_nextdata_n, 1);
        check("lat_valid_n2", evt_valid, 1);
        check("lat_head_n2", {evt_ext, evt_break, evt_code}, 10'h01C);
        seq = '{8'hF0, 8'h1C}; feed();
        check_state("basic"); drain("basic");

        // Extended make/break
        seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}; feed();
        check_state("ext"); drain("ext");

        // Shift and caps-lock with held repeat
        seq = '{8'h12};        feed(); check("mods_shift", mods, 4'b0001);
        seq = '{8'h58};        feed(); check("mods_caps_on", mods, 4'b1001);
        seq = '{8'h58};        feed(); check("mods_caps_repeat", mods, 4'b1001);
        seq = '{8'hF0, 8'h58}; feed(); check("mods_caps_rel", mods, 4'b1001);
        seq = '{8'hF0, 8'h12}; feed(); check("mods_shift_rel", mods, 4'b1000);
        drain("mods");

        // Pause sequence swallowed
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C}; feed();
        check("pause_count", count, 1);
        check("pause_head", {evt_ext, evt_break, evt_code}, 10'h01C);
        check_state("pause"); drain("pause");
        seq = '{8'hF0, 8'h1C}; feed(); drain("pause_rel");

        // Typematic repeat filter
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}; feed();
`ifdef KBD_REPEAT_FILTER_EN
        check("repeat_count", count, 2);
`else
        check("repeat_count", count, 4);
`endif
        check_state("repeat"); drain("repeat");

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) seq.push_back(8'(8'h21 + i));
        feed();
        check("full_count", count, 8);
        check("full_evt_ovf", evt_ovf, 1);
        ovf_clr = 1; step(); ovf_clr = 0; m_evt_ovf = 0;
        check("ovf_cleared", evt_ovf, 0);

        // Push and pop in the same cycle while full
        rx_q.push_back(8'h2A); fed++;
        void'(exp_q.pop_front()); model_byte(8'h2A);
        drive_rx();
        step();
        rd_en = 1; step(); rd_en = 0;
        repeat (2) step();
        check("fullpp_count", count, 8);
        check("fullpp_evt_ovf", evt_ovf, 0);
        drain("fullpp");

        // rd_en while empty is ignored
        rd_en = 1; step(); rd_en = 0;
        check("empty_pop_count", count, 0);
        check("empty_pop_valid", evt_valid, 0);

        // ps2_ovf sticky, set beats clear
        ps2_overflow = 1; step(); ps2_overflow = 0; m_ps2_ovf = 1;
        check("ps2_ovf_set", ps2_ovf, 1);
        ps2_overflow = 1; ovf_clr = 1; step(); ps2_overflow = 0; ovf_clr = 0;
        check("ps2_ovf_set_wins", ps2_ovf, 1);
        ovf_clr = 1; step(); ovf_clr = 0; m_ps2_ovf = 0;
        check("ps2_ovf_clr", ps2_ovf, 0);

        // Randomized byte streams
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                ovf_clr = 1; step(); ovf_clr = 0; m_evt_ovf = 0; m_ps2_ovf = 0;
            end
            if ($urandom_range(0, 3) == 0) begin
                ps2_overflow = 1; step(); ps2_overflow = 0; m_ps2_ovf = 1;
            end
            for (int k = 0, n = $urandom_range(1, 10); k < n; k++) seq.push_back(pick_byte());
            feed();
            check_state("rand");
            if ($urandom_range(0, 1) == 0) drain("rand");
        end
        drain("rand_final");

        // Reset in the middle of a break prefix
        seq = '{8'h12, 8'hF0}; feed();
        #2 clrn = 0;
        #1 check_reset_outputs("midreset");
        @(posedge clk); #1;
        clrn = 1;
        rx_q.delete(); drive_rx(); model_reset();
        step();
        seq = '{8'h1C}; feed();
        check("postreset_head", {evt_ext, evt_break, evt_code}, 10'h01C);
        check_state("postreset"); drain("postreset");

        check("strobe_per_byte", lows, pops);
        check("bytes_consumed", pops, fed);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Controller that sequences the PS/2 receiver's byte FIFO (`ps2_keyboard`) through its `ready`/`nextdata_n` pop handshake and decodes raw scancode bytes (set 2, with E0/F0/E1 prefixes) into complete key events. It tracks modifier state and buffers events in a small FIFO that the CPU bus side reads. It sits between `ps2_keyboard` and the memory-mapped keyboard register block and replaces ad-hoc per-byte decoding.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, 2..64.
- `clk` input 1: system clock, all logic on rising edge.
- `clrn` input 1: asynchronous, active-low reset.
- `ps2_ready` input 1: receiver byte available. Connects to `ready`.
- `ps2_data` input 8: receiver head byte. Connects to `data`.
- `ps2_overflow` input 1: receiver overflow flag.
- `ps2_nextdata_n` output 1: active-low pop strobe to the receiver.
- `rd_en` input 1: pop the head event when high for one cycle.
- `evt_valid` output 1: event FIFO not empty.
- `evt_code` output 8: head event scancode; first-word-fall-through.
- `evt_ext` output 1: head event had an E0 prefix.
- `evt_break` output 1: head event is a release.
- `mods` output 4: `{caps_lock, alt, ctrl, shift}`.
- `ovf_clr` input 1: clears both sticky overflow flags.
- `evt_ovf` output 1: sticky flag; an event was dropped because the FIFO was full.
- `ps2_ovf` output 1: sticky flag; `ps2_overflow` was seen high.
- `count` output `$clog2(FIFO_DEPTH)+1`: number of events in the FIFO.

## Operation
- Reset values:
  - FSM is in IDLE.
  - `ps2_nextdata_n`=1.
  - FIFO is empty, so `evt_valid`=0, `count`=0, and `evt_code`/`evt_ext`/`evt_break` read as 0.
  - `mods`=0, `evt_ovf`=0, `ps2_ovf`=0.
  - Prefix flags are cleared, the E1 skip counter is 0, and `last_make` is invalid.
- FSM states:
  - IDLE: if `ps2_ready`, capture `ps2_data` and go to DECODE.
  - DECODE: drive `ps2_nextdata_n`=0 for this cycle only, decode the captured byte, and go to GAP.
  - GAP: drive `ps2_nextdata_n`=1 and go to IDLE. The gap lets `ps2_ready` reflect the post-pop state.
- Decode rules, applied in DECODE, in priority order:
  1. If the E1 skip counter is nonzero: decrement it and discard the byte.
  2. E1: load the skip counter with 7 and discard the byte. This drops the Pause sequence and emits no event.
  3. E0: set the `ext` flag.
  4. F0: set the `brk` flag.
  5. Any other byte: form the event `{ext, brk, byte}`, push it (subject to the repeat filter), then clear `ext` and `brk`.
- Modifiers, updated on every formed event including filtered ones:
  - shift = L-shift (12) or R-shift (59) held; each key is tracked separately.
  - ctrl = 14, with or without ext.
  - alt = 11, with or without ext.
  - caps_lock (58) toggles on a make only when it was not already held. It tracks a held bit, so typematic repeats never re-toggle.
- FIFO behaviour:
  - Push when full: the event is dropped and `evt_ovf` is set.
  - Push and `rd_en` in the same cycle while full: the pop is honoured and the push is accepted.
  - `rd_en` while empty: ignored.
- `ps2_ovf` is set on any cycle with `ps2_overflow`=1.
- `ovf_clr` clears both sticky flags. If `ovf_clr` and a new set condition occur in the same cycle, the set wins.
- Reset mid-sequence discards any partial prefix. No event is emitted.

## Timing
- Byte throughput: at most one byte per 3 cycles.
- Latency: `ps2_ready` sampled high in IDLE at cycle n → `ps2_nextdata_n` low in cycle n+1 → event visible on `evt_valid`/head outputs in cycle n+2, if the FIFO was empty. `mods` updates in that same cycle n+2.
- `rd_en` at cycle m: the next head (or `evt_valid`=0) appears at cycle m+1, and `count` updates at m+1.
- `ps2_nextdata_n` is low for exactly one cycle per consumed byte. It is never low when `ps2_ready` was low in the capturing IDLE cycle.

## Configuration
- Macro: `KBD_REPEAT_FILTER_EN`.
- Defined:
  - A make event whose `{ext, code}` equals the valid `last_make` is not pushed; this suppresses typematic repeats.
  - Every pushed make loads `last_make`.
  - A break matching `last_make` invalidates it.
- Undefined: every formed event is pushed, and the `last_make` logic is absent.

## Structure
- Package `kbd_pkg` holds:
  - `kbd_evt_t` struct: `ext`, `brk`, `code[7:0]`.
  - FSM state enum: IDLE, DECODE, GAP.
  - Scancode constants: prefixes E0, F0, E1 and codes 12, 59, 14, 11, 58.
  - The E1 skip length, 7.
- Sub-module `kbd_evt_fifo`: parameterised FWFT FIFO of `kbd_evt_t` with push/pop/full/empty/count.
- FSM, decode, modifiers and sticky flags live in the top module.

## Test plan
- Bytes 1C, F0 1C → event {0,0,1C}, then {0,1,1C}. Each `ps2_nextdata_n` pulse is 1 cycle, and the first event appears 2 cycles after the first `ps2_ready`.
- Bytes E0 75, E0 F0 75 → events {1,0,75} and {1,1,75}.
- Bytes 12, 58, 58, F0 58, F0 12 → `mods` goes 0001, 1001 (held repeat, no toggle), and ends at 1000.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C → the only event is {0,0,1C}.
- With `KBD_REPEAT_FILTER_EN`, bytes 1C 1C 1C F0 1C → 2 events. Without the macro → 4 events.
- Push 9 events with `FIFO_DEPTH`=8 and no reads → `count`=8 and `evt_ovf`=1. Pulse `ovf_clr` → `evt_ovf`=0. Assert `clrn` low mid-prefix (after F0) → all outputs return to their reset values.
